insn_fetch: RTL and testbench
=============================

# insn_fetch

Instruction fetch and decode stage directly upstream of `control`. Holds the program counter and fetches one instruction word at a time over a valid/ready instruction-memory port. It decodes the opcode into the one-hot `insn_en` vector that `control` consumes, and holds that decode stable until the execute side retires the instruction. It advances the PC by 1 or 2 according to the `pc_sel` that `control` derives.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width.
- `INSN_W`, 8: instruction word width.
- `OPCODE_W`, 4: opcode field width, taken from the MSBs of the word.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out ADDR_W: fetch address, equals `pc` while `imem_req` is high.
- `imem_ready` in 1: memory accepts the request; the handshake completes on `imem_req && imem_ready`.
- `imem_rvalid` in 1: read data valid, one-cycle pulse.
- `imem_rdata` in INSN_W: instruction word.
- `pc_sel` in 1: from `control`. LOW advances PC by 1, HIGH advances PC by 2.
- `retire` in 1: the current instruction has completed. Sampled only in HOLD.
- `insn_valid` out 1: `insn_en`, `operand` and `illegal` are valid.
- `insn_en` out `ISA_INSN_COUNT`: one-hot decoded instruction, feeds `control`.
- `operand` out INSN_W-OPCODE_W: low field of the word (register index or immediate).
- `illegal` out 1: the opcode is `>= ISA_INSN_COUNT`.
- `pc` out ADDR_W: current PC, used by the ALU A-input path.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release, then go to REQ.
- REQ: `imem_req`=1 and `imem_addr`=`pc`. On `imem_ready`, go to WAIT. Address and request stay stable until accepted.
- WAIT: `imem_req`=0. On `imem_rvalid`, capture the decode of `imem_rdata` and go to HOLD.
- HOLD: `insn_valid`=1 and the decode outputs are frozen. On `retire`, set `pc <= pc + (pc_sel ? 2 : 1)` modulo 2^ADDR_W and go to REQ.
- Decode:
  - opcode = `imem_rdata[INSN_W-1 -: OPCODE_W]`.
  - If opcode < `ISA_INSN_COUNT`: `insn_en` = 1 << opcode and `illegal`=0.
  - Otherwise: `insn_en`=0 and `illegal`=1. The word is still held, and `retire` still advances the PC.
- `imem_rvalid` outside WAIT is ignored, including a stale response after reset.
- `retire` outside HOLD is ignored.
- `pc_sel` is sampled only in the cycle `retire` is accepted.
- PC wrap: the increment truncates to ADDR_W bits (255+1 = 0 and 255+2 = 1 at ADDR_W=8).

## Timing
- Reset values:
  - `pc`=RESET_PC, state=IDLE.
  - `imem_req`=0, `insn_valid`=0, `insn_en`=0, `operand`=0, `illegal`=0.
  - `imem_addr` follows `pc`.
- Reset asserted mid-fetch or mid-HOLD clears all state immediately (asynchronous). Nothing of the in-flight instruction is kept.
- Best case: `imem_req` rises 2 cycles after `rst_n` deasserts. With `imem_ready`=1 and `imem_rvalid` on the next cycle, `insn_valid` rises 2 cycles after the request cycle.
- `insn_valid` drops in the cycle after `retire` is accepted, when state is REQ. Minimum retire-to-next-valid is 3 cycles with zero-wait memory.
- All outputs are registered except `imem_addr` and `pc`, which are registered PC values. There are no combinational paths from inputs to outputs.

## Structure
- `ISA_INSN_COUNT`, `ALU_MODE_COUNT` and the opcode encodings stay in the shared ISA defines file, and this block includes it.
- FSM state encodings are local parameters.
- Natural sub-module: `insn_decode`, combinational opcode → one-hot plus `illegal`. It is reusable by a future disassembler or trace monitor.

## Test plan
- Reset release, `imem_ready`=1, rvalid one cycle after accept with word 0x23 (opcode 2, ISA_INSN_COUNT=8):
  - `imem_req` seen at addr 0.
  - Then `insn_valid`=1, `insn_en`=8'b0000_0100, `operand`=3, `illegal`=0.
- Retire with `pc_sel`=0, then retire with `pc_sel`=1 → fetch addresses 0, 1, 3.
- `imem_ready` held low 5 cycles in REQ → `imem_req` and `imem_addr` stay constant. WAIT is entered only on the accepting cycle.
- Word 0xF0 (opcode 15 ≥ 8) → `insn_en`=0, `illegal`=1. Retire advances the PC normally.
- PC at 255, retire with `pc_sel`=1 → next fetch addr 1.
- `rst_n` pulsed low while in WAIT, then a stale `imem_rvalid` arrives during IDLE → it is ignored, and the next fetch is at RESET_PC.

Source files
------------

// File: rtl/insn_fetch_pkg.sv
// Shared ISA definitions and fetch-stage types for the instruction fetch/decode path.
// The opcode encodings here are the ones the control block keys off.
package insn_fetch_pkg;

    localparam int ISA_INSN_COUNT = 8;
    localparam int ALU_MODE_COUNT = 4;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/insn_decode.sv
// Combinational opcode decoder: instruction word to one-hot enable, operand field and illegal flag.
// Kept standalone so trace monitors or a disassembler can reuse it.
module insn_decode
    import insn_fetch_pkg::*;
#(
    parameter int INSN_W   = 8,
    parameter int OPCODE_W = 4
) (
    input  logic [INSN_W-1:0]          word,
    output logic [ISA_INSN_COUNT-1:0]  insn_en,
    output logic [INSN_W-OPCODE_W-1:0] operand,
    output logic                       illegal
);

    logic [OPCODE_W-1:0] opcode;

    always_comb begin
        opcode  = word[INSN_W-1 -: OPCODE_W];
        operand = word[INSN_W-OPCODE_W-1:0];
        insn_en = '0;
        illegal = 1'b1;
        if (int'(opcode) < ISA_INSN_COUNT) begin
            insn_en = ISA_INSN_COUNT'(1) << opcode;
            illegal = 1'b0;
        end
    end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word over a valid/ready port,
// and holds its registered decode steady until the execute side retires it.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 8,
    parameter int              INSN_W   = 8,
    parameter int              OPCODE_W = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [INSN_W-1:0]          imem_rdata,
    input  logic                       pc_sel,
    input  logic                       retire,
    output logic                       insn_valid,
    output logic [ISA_INSN_COUNT-1:0]  insn_en,
    output logic [INSN_W-OPCODE_W-1:0] operand,
    output logic                       illegal,
    output logic [ADDR_W-1:0]          pc
);

    fetch_state_t state, state_next;

    logic [ADDR_W-1:0]          pc_q;
    logic [ISA_INSN_COUNT-1:0]  dec_en;
    logic [INSN_W-OPCODE_W-1:0] dec_operand;
    logic                       dec_illegal;

    insn_decode #(
        .INSN_W   (INSN_W),
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .word    (imem_rdata),
        .insn_en (dec_en),
        .operand (dec_operand),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ:  if (imem_ready)  state_next = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_next = ST_HOLD;
            ST_HOLD: if (retire)      state_next = ST_REQ;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request and valid are pure decodes of the state flops, so no input reaches them combinationally.
    always_comb begin
        imem_req   = (state == ST_REQ);
        insn_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (state == ST_HOLD && retire) begin
            pc_q <= pc_q + (pc_sel ? ADDR_W'(2) : ADDR_W'(1));
        end
    end

    // Decode is captured only on the response we are waiting for; anything else is a stale beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_en <= '0;
            operand <= '0;
            illegal <= 1'b0;
        end else if (state == ST_WAIT && imem_rvalid) begin
            insn_en <= dec_en;
            operand <= dec_operand;
            illegal <= dec_illegal;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed self-checking bench for insn_fetch: fetch/decode, PC stepping, stalls, illegal opcodes,
// PC wrap and asynchronous reset with a stale memory response.
module tb_insn_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ready;
    logic       imem_rvalid;
    logic [7:0] imem_rdata;
    logic       pc_sel;
    logic       retire;
    logic       insn_valid;
    logic [7:0] insn_en;
    logic [3:0] operand;
    logic       illegal;
    logic [7:0] pc;

    int checks   = 0;
    int failures = 0;

    insn_fetch #(
        .ADDR_W   (8),
        .INSN_W   (8),
        .OPCODE_W (4),
        .RESET_PC (8'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_sel      (pc_sel),
        .retire      (retire),
        .insn_valid  (insn_valid),
        .insn_en     (insn_en),
        .operand     (operand),
        .illegal     (illegal),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic rvalid, input logic [7:0] rdata,
                                 input logic ret, input logic sel);
        imem_ready  = ready;
        imem_rvalid = rvalid;
        imem_rdata  = rdata;
        retire      = ret;
        pc_sel      = sel;
    endtask

    // Waits (bounded) at negedges for a request, then checks its address.
    task automatic waitReq(input logic [7:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("req_seen", 32'(seen), 32'd1);
        checkOutput("req_addr", 32'(imem_addr), 32'(exp_addr));
    endtask

    task automatic fetchInsn(input logic [7:0] exp_addr, input logic [7:0] word, input int stall,
                             input logic [7:0] exp_en, input logic [3:0] exp_op, input logic exp_ill);
        waitReq(exp_addr);
        for (int i = 0; i < stall; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("stall_req", 32'(imem_req), 32'd1);
            checkOutput("stall_addr", 32'(imem_addr), 32'(exp_addr));
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("wait_req", 32'(imem_req), 32'd0);
        checkOutput("wait_valid", 32'(insn_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, word, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("hold_valid", 32'(insn_valid), 32'd1);
        checkOutput("hold_en", 32'(insn_en), 32'(exp_en));
        checkOutput("hold_operand", 32'(operand), 32'(exp_op));
        checkOutput("hold_illegal", 32'(illegal), 32'(exp_ill));
    endtask

    task automatic retireInsn(input logic sel);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, sel);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("retire_valid", 32'(insn_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(insn_valid), 32'd0);
        checkOutput("rst_en", 32'(insn_en), 32'd0);
        checkOutput("rst_operand", 32'(operand), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);

        rst_n = 1'b1;
        fetchInsn(8'd0, 8'h23, 0, 8'b0000_0100, 4'd3, 1'b0);
        // Hold must survive a few idle cycles without retire.
        repeat (3) @(negedge clk);
        checkOutput("hold_stable_valid", 32'(insn_valid), 32'd1);
        checkOutput("hold_stable_en", 32'(insn_en), 32'h04);
        retireInsn(1'b0);
        checkOutput("pc_after_sel0", 32'(pc), 32'd1);

        fetchInsn(8'd1, 8'h51, 5, 8'b0010_0000, 4'd1, 1'b0);
        retireInsn(1'b1);
        checkOutput("pc_after_sel1", 32'(pc), 32'd3);

        fetchInsn(8'd3, 8'hF0, 0, 8'h00, 4'd0, 1'b1);
        retireInsn(1'b0);
        checkOutput("pc_after_illegal", 32'(pc), 32'd4);

        for (int a = 4; a <= 252; a += 2) begin
            fetchInsn(8'(a), 8'h70, 0, 8'h80, 4'd0, 1'b0);
            retireInsn(1'b1);
        end
        fetchInsn(8'd254, 8'h6A, 0, 8'h40, 4'hA, 1'b0);
        retireInsn(1'b0);
        fetchInsn(8'd255, 8'h15, 0, 8'h02, 4'd5, 1'b0);
        retireInsn(1'b1);
        checkOutput("pc_wrap", 32'(pc), 32'd1);

        // Accept a request at address 1, then reset while the response is outstanding.
        waitReq(8'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pc", 32'(pc), 32'd0);
        checkOutput("async_rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("stale_valid", 32'(insn_valid), 32'd0);
        checkOutput("stale_en", 32'(insn_en), 32'd0);
        fetchInsn(8'd0, 8'h12, 0, 8'b0000_0010, 4'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
